// File: rtl/nios2_ls_de2_pio_switch18_irq.sv
// rtl/nios2_ls_de2_pio_switch18_irq.sv - switch input PIO with edge capture and masked irq
// Avalon-MM slave: data / direction / interruptmask / edgecapture registers.
module nios2_ls_de2_pio_switch18_irq #(
  parameter int WIDTH     = 18,
  parameter int EDGE_TYPE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic             r_irq;

  logic             w_wr;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd;
  logic             w_unused_wdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_mask = w_wr & (address == ADDR_MASK);
  assign w_wr_edge = w_wr & (address == ADDR_EDGE);
  assign w_wdata   = writedata[WIDTH-1:0];
  assign w_unused_wdata = &{1'b0, writedata};

  // s1/s2 resynchronise the switches; s3 is the previous s2 sample for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  generate
    if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge = ~r_s2 & r_s3;
    end else if (EDGE_TYPE == 2) begin : g_any
      assign w_edge = r_s2 ^ r_s3;
    end else begin : g_rise
      assign w_edge = r_s2 & ~r_s3;
    end
  endgenerate

  assign w_clr = w_wr_edge ? w_wdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_wr_mask) begin
      r_mask <= w_wdata;
    end
  end

  // a new edge wins over a software clear landing in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_edge;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_cap & r_mask);
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA: w_rd = 32'(r_s2);
      ADDR_DIR:  w_rd = '0;
      ADDR_MASK: w_rd = 32'(r_mask);
      ADDR_EDGE: w_rd = 32'(r_cap);
      default:   w_rd = '0;
    endcase
  end

  assign readdata = w_rd;
  assign irq      = r_irq;

endmodule

// File: tb/tb_nios2_ls_de2_pio_switch18_irq.sv
// tb/tb_nios2_ls_de2_pio_switch18_irq.sv - self-checking bench for the switch PIO
// Three instances (rising, falling, any edge) share one bus and one switch input.
module tb_nios2_ls_de2_pio_switch18_irq;

  localparam int W = 18;
  localparam logic [W-1:0] ALL = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2_ls_de2_pio_switch18_irq #(.WIDTH(W), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));
  nios2_ls_de2_pio_switch18_irq #(.WIDTH(W), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));
  nios2_ls_de2_pio_switch18_irq #(.WIDTH(W), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  // Reference model: the last three sampled switch words, one capture word and irq per edge kind
  logic [W-1:0] hist [3];
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [3];
  logic         m_irq [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hist[k] = '0;
      m_cap[k] = '0;
      m_irq[k] = 1'b0;
    end
    m_mask = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] now, prev, ev;
    logic wr;
    now  = hist[1];
    prev = hist[2];
    wr = chipselect && !write_n;
    for (int k = 0; k < 3; k++) begin
      m_irq[k] = (m_cap[k] & m_mask) != 0;
      case (k)
        0: ev = now & ~prev;
        1: ev = ~now & prev;
        default: ev = now ^ prev;
      endcase
      if (wr && address == 2'd3) m_cap[k] = m_cap[k] & ~writedata[W-1:0];
      m_cap[k] = m_cap[k] | ev;
    end
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = in_port;
  endtask

  function automatic logic [31:0] exp_rd(int k, logic [1:0] a);
    case (a)
      2'd0: return 32'(hist[1]);
      2'd2: return 32'(m_mask);
      2'd3: return 32'(m_cap[k]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
    address = 2'd0;
  endtask

  task automatic read3(input logic [1:0] a, output logic [31:0] v0,
                       output logic [31:0] v1, output logic [31:0] v2);
    address = a;
    #1;
    v0 = rd0;
    v1 = rd1;
    v2 = rd2;
  endtask

  // Compares every register of every instance plus irq against the model (4 ns after negedge)
  task automatic check_regs(input string tag);
    logic [31:0] v0, v1, v2;
    for (int a = 0; a < 4; a++) begin
      read3(2'(a), v0, v1, v2);
      chk($sformatf("%s rise a%0d", tag, a), v0, exp_rd(0, 2'(a)));
      chk($sformatf("%s fall a%0d", tag, a), v1, exp_rd(1, 2'(a)));
      chk($sformatf("%s any a%0d", tag, a), v2, exp_rd(2, 2'(a)));
    end
    chk({tag, " irq rise"}, {31'd0, irq0}, {31'd0, m_irq[0]});
    chk({tag, " irq fall"}, {31'd0, irq1}, {31'd0, m_irq[1]});
    chk({tag, " irq any"},  {31'd0, irq2}, {31'd0, m_irq[2]});
    address = 2'd0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] v0, v1, v2;
    model_reset();

    // Reset with all switches high
    in_port = ALL;
    @(negedge clk);
    tick();
    check_regs("in_reset");
    reset = 1'b0;
    tick();
    tick();
    read3(2'd0, v0, v1, v2);
    chk("addr0 two clocks after release", v0, 32'h0003FFFF);
    check_regs("release+2");
    tick();
    read3(2'd3, v0, v1, v2);
    chk("rise cap three clocks after release", v0, 32'h0003FFFF);
    chk("fall cap after release", v1, 32'h0);
    chk("irq masked after release", {31'd0, irq0}, 32'h0);
    check_regs("release+3");

    // Single rising edge through to irq and clear
    bus_write(2'd3, 32'h3FFFF);
    bus_write(2'd2, 32'h00001);
    in_port = '0;
    settle(4);
    bus_write(2'd3, 32'h3FFFF);
    settle(2);
    check_regs("quiet");
    in_port = 18'h00001;
    tick();
    tick();
    read3(2'd3, v0, v1, v2);
    chk("cap before E3", v0, 32'h0);
    tick();
    read3(2'd3, v0, v1, v2);
    chk("cap at E3", v0, 32'h00001);
    chk("irq low at E3", {31'd0, irq0}, 32'h0);
    tick();
    chk("irq at E4", {31'd0, irq0}, 32'h1);
    check_regs("E4");
    bus_write(2'd3, 32'h1);
    read3(2'd3, v0, v1, v2);
    chk("cap cleared", v0, 32'h0);
    tick();
    chk("irq dropped", {31'd0, irq0}, 32'h0);
    check_regs("cleared");

    // Falling-edge instance: only the 1->0 transition of bit 5 captures
    bus_write(2'd3, 32'h3FFFF);
    in_port = 18'h00021;
    settle(4);
    read3(2'd3, v0, v1, v2);
    chk("fall ignores rising bit5", v1, 32'h0);
    in_port = 18'h00001;
    settle(4);
    read3(2'd3, v0, v1, v2);
    chk("fall captures bit5", v1, 32'h00020);
    check_regs("fall");

    // Set beats clear on bit 3; plain clear on bit 4
    bus_write(2'd3, 32'h3FFFF);
    in_port = 18'h00011;
    settle(4);
    read3(2'd3, v0, v1, v2);
    chk("bit4 captured", v0, 32'h00010);
    in_port = 18'h00019;
    tick();
    tick();
    bus_write(2'd3, 32'h18);
    read3(2'd3, v0, v1, v2);
    chk("set priority bit3, bit4 cleared", v0, 32'h00008);
    check_regs("priority");

    // Writes to data/direction are ignored; mask truncates to WIDTH
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_write(2'd1, 32'hFFFFFFFF);
    read3(2'd0, v0, v1, v2);
    chk("addr0 follows switches", v0, 32'(in_port));
    read3(2'd1, v0, v1, v2);
    chk("addr1 reads zero", v0, 32'h0);
    bus_write(2'd2, 32'hFFFFFFFF);
    read3(2'd2, v0, v1, v2);
    chk("mask truncated", v0, 32'h0003FFFF);

    // Mask/unmask a pending bit
    bus_write(2'd2, 32'h0);
    tick();
    chk("masked pending irq low", {31'd0, irq0}, 32'h0);
    read3(2'd3, v0, v1, v2);
    chk("masking keeps capture", v0, 32'h00008);
    bus_write(2'd2, 32'h8);
    chk("irq not yet at unmask edge", {31'd0, irq0}, 32'h0);
    tick();
    chk("unmasked irq high", {31'd0, irq0}, 32'h1);

    // Asynchronous reset while irq is high
    bus_write(2'd2, 32'h3FFFF);
    tick();
    chk("irq before async reset", {31'd0, irq0}, 32'h1);
    address = 2'd2;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mask zero on reset", rd0, 32'h0);
    chk("irq low on reset", {31'd0, irq0}, 32'h0);
    address = 2'd3;
    #1;
    chk("cap zero on reset", rd0, 32'h0);
    address = 2'd0;
    @(negedge clk);
    tick();
    reset = 1'b0;
    in_port = '0;
    settle(4);
    check_regs("post_reset");

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        address = 2'($urandom_range(0, 3));
        writedata = (address == 2'd3 && $urandom_range(0, 1) == 1) ? 32'(1 << $urandom_range(0, W - 1))
                                                                     : $urandom;
        chipselect = 1'b1;
        write_n = 1'b0;
      end else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n = 1'b1;
      end
      tick();
      chipselect = 1'b0;
      write_n = 1'b1;
      check_regs($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
